pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl_hazard_cmp.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Sequencer states; encoding is visible on the ctrl_state port.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_t;

  // Bit positions inside the decode-stage used_RmRnRd vector.
  localparam int USED_RM = 2;
  localparam int USED_RN = 1;
  localparam int USED_RD = 0;

  // Position of the load flag inside the pipeline control word.
  localparam int LOADS_BIT = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int PERF_W = 16
);
  logic              dec_valid;
  logic [2:0]        dec_num_Rm;
  logic [2:0]        dec_num_Rn;
  logic [2:0]        dec_num_Rd;
  logic [2:0]        dec_used_RmRnRd;
  logic              rr_loads;
  logic [2:0]        rr_num_Rd;
  logic              mem_req;
  logic              mem_ready;
  logic              branch_taken;
  logic              update_if;
  logic              update_rr;
  logic              update_ex;
  logic              update_mem;
  logic              bubble_rr;
  logic              flush_if;
  logic [1:0]        ctrl_state;
  logic [PERF_W-1:0] perf_stall_cnt;
  logic [PERF_W-1:0] perf_flush_cnt;

  modport master (
    output dec_valid, dec_num_Rm, dec_num_Rn, dec_num_Rd, dec_used_RmRnRd,
           rr_loads, rr_num_Rd, mem_req, mem_ready, branch_taken,
    input  update_if, update_rr, update_ex, update_mem, bubble_rr, flush_if,
           ctrl_state, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  dec_valid, dec_num_Rm, dec_num_Rn, dec_num_Rd, dec_used_RmRnRd,
           rr_loads, rr_num_Rd, mem_req, mem_ready, branch_taken,
    output update_if, update_rr, update_ex, update_mem, bubble_rr, flush_if,
           ctrl_state, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// Load-use detector: a load in readreg whose destination is read by decode.
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic       dec_valid,
  input  logic [2:0] num_rm,
  input  logic [2:0] num_rn,
  input  logic [2:0] num_rd,
  input  logic [2:0] used,
  input  logic       rr_loads,
  input  logic [2:0] rr_num_rd,
  output logic       hazard
);

  assign hazard = dec_valid & rr_loads &
                  ((used[USED_RM] & (num_rm == rr_num_rd)) |
                   (used[USED_RN] & (num_rn == rr_num_rd)) |
                   (used[USED_RD] & (num_rd == rr_num_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: stage update enables, readreg bubbles and
// fetch flushes for load-use hazards, memory waits and taken branches.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int PERF_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  pipeline_hazard_ctrl_if.slave   bus
);

  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_CYCLES - 1);

  state_t     state, state_d;
  logic [1:0] cnt, cnt_d;
  logic       pend, pend_d;
  logic       hazard, mem_stall;
  logic       upd_if, upd_back, bub, fl;

  hazard_cmp u_cmp (
    .dec_valid (bus.dec_valid),
    .num_rm    (bus.dec_num_Rm),
    .num_rn    (bus.dec_num_Rn),
    .num_rd    (bus.dec_num_Rd),
    .used      (bus.dec_used_RmRnRd),
    .rr_loads  (bus.rr_loads),
    .rr_num_rd (bus.rr_num_Rd),
    .hazard    (hazard)
  );

  assign mem_stall = bus.mem_req & ~bus.mem_ready;

  // State, stall counter and pending-branch flag registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state <= RUN;
      cnt   <= 2'd0;
      pend  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pend  <= pend_d;
    end
  end

  // Next-state and output decode; priority mem_stall > branch > hazard.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d  = state;
    cnt_d    = cnt;
    pend_d   = pend;
    upd_if   = 1'b0;
    upd_back = 1'b0;
    bub      = 1'b0;
    fl       = 1'b0;
    unique case (state)
      RUN, FLUSH: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          pend_d  = bus.branch_taken;
        end else if (bus.branch_taken) begin
          {upd_if, upd_back, bub, fl} = 4'b1111;
          state_d = FLUSH;
        end else if (state == FLUSH) begin
          // Second younger instruction is dropped; its hazard is moot.
          {upd_if, upd_back, bub} = 3'b111;
          state_d = RUN;
        end else if (hazard) begin
          {upd_back, bub} = 2'b11;
          cnt_d   = STALL_INIT;
          state_d = (LOAD_USE_CYCLES > 1) ? LOAD_STALL : RUN;
        end else begin
          {upd_if, upd_back} = 2'b11;
        end
      end
      LOAD_STALL: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          cnt_d   = 2'd0;
          pend_d  = bus.branch_taken;
        end else if (bus.branch_taken) begin
          {upd_if, upd_back, bub, fl} = 4'b1111;
          cnt_d   = 2'd0;
          state_d = FLUSH;
        end else begin
          {upd_back, bub} = 2'b11;
          // Leave once the decremented count reaches zero.
          cnt_d   = (cnt != 2'd0) ? cnt - 2'd1 : 2'd0;
          state_d = (cnt <= 2'd1) ? RUN : LOAD_STALL;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          {upd_if, upd_back} = 2'b11;
          pend_d = 1'b0;
          if (pend | bus.branch_taken) begin
            {bub, fl} = 2'b11;
            state_d   = FLUSH;
          end else begin
            state_d = RUN;
          end
        end else begin
          pend_d = pend | bus.branch_taken;
        end
      end
      default: state_d = RUN;
    endcase
    // Reset freezes every stage regardless of state.
    if (!rst) begin
      upd_if   = 1'b0;
      upd_back = 1'b0;
      bub      = 1'b0;
      fl       = 1'b0;
    end
  end

  assign bus.update_if  = upd_if;
  assign bus.update_rr  = upd_back;
  assign bus.update_ex  = upd_back;
  assign bus.update_mem = upd_back;
  assign bus.bubble_rr  = bub;
  assign bus.flush_if   = fl;
  assign bus.ctrl_state = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  // Saturating counters of frozen-fetch cycles and fetch flushes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!upd_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
      if (fl && (flush_cnt != '1))      flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end

  assign bus.perf_stall_cnt = stall_cnt;
  assign bus.perf_flush_cnt = flush_cnt;
`else
  assign bus.perf_stall_cnt = '0;
  assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle vector table from RUN
// plus hand sequences for stalls, memory waits and branch flushes.
// Two instances run in parallel: LOAD_USE_CYCLES=1 and LOAD_USE_CYCLES=2.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.PERF_W(16)) bus1 ();
  pipeline_hazard_ctrl_if #(.PERF_W(16)) bus2 ();

  pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(1), .PERF_W(16)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );
  pipeline_hazard_ctrl #(.LOAD_USE_CYCLES(2), .PERF_W(16)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic       dv;
    logic [2:0] rm, rn, rd, used;
    logic       rl;
    logic [2:0] rrd;
    logic       mreq, mrdy, br;
    logic [3:0] e_upd;   // {if, rr, ex, mem}
    logic       e_bub, e_fl;
    logic [1:0] e_next;
  } vec_t;

  vec_t vecs[14];
  vec_t cur;

  function automatic vec_t mk(string name, logic dv, logic [2:0] rm, logic [2:0] rn,
                              logic [2:0] rd, logic [2:0] used, logic rl, logic [2:0] rrd,
                              logic mreq, logic mrdy, logic br, logic [3:0] e_upd,
                              logic e_bub, logic e_fl, logic [1:0] e_next);
    vec_t v;
    v.name = name; v.dv = dv; v.rm = rm; v.rn = rn; v.rd = rd; v.used = used;
    v.rl = rl; v.rrd = rrd; v.mreq = mreq; v.mrdy = mrdy; v.br = br;
    v.e_upd = e_upd; v.e_bub = e_bub; v.e_fl = e_fl; v.e_next = e_next;
    return v;
  endfunction

  function automatic vec_t idle_vec();
    return mk("idle", 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 4'hF, 0, 0, 2'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus1.dec_valid = v.dv;  bus2.dec_valid = v.dv;
    bus1.dec_num_Rm = v.rm; bus2.dec_num_Rm = v.rm;
    bus1.dec_num_Rn = v.rn; bus2.dec_num_Rn = v.rn;
    bus1.dec_num_Rd = v.rd; bus2.dec_num_Rd = v.rd;
    bus1.dec_used_RmRnRd = v.used; bus2.dec_used_RmRnRd = v.used;
    bus1.rr_loads = v.rl;   bus2.rr_loads = v.rl;
    bus1.rr_num_Rd = v.rrd; bus2.rr_num_Rd = v.rrd;
    bus1.mem_req = v.mreq;  bus2.mem_req = v.mreq;
    bus1.mem_ready = v.mrdy; bus2.mem_ready = v.mrdy;
    bus1.branch_taken = v.br; bus2.branch_taken = v.br;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] upd1();
    return {bus1.update_if, bus1.update_rr, bus1.update_ex, bus1.update_mem};
  endfunction

  // Checks the L=1 instance outputs against expected update/bubble/flush.
  task automatic chk_out(input string tag, input logic [3:0] upd, input logic bub, input logic fl);
    check({tag, "_upd"},   32'(upd1()),         32'(upd));
    check({tag, "_bub"},   32'(bus1.bubble_rr), 32'(bub));
    check({tag, "_flush"}, 32'(bus1.flush_if),  32'(fl));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(idle_vec());
    cyc();
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk("idle",      0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 4'hF, 0, 0, 2'd0);
    vecs[1]  = mk("rn_haz",    1, 0, 3, 0, 3'b010, 1, 3, 0, 0, 0, 4'h7, 1, 0, 2'd0);
    vecs[2]  = mk("rn_unused", 1, 0, 3, 0, 3'b000, 1, 3, 0, 0, 0, 4'hF, 0, 0, 2'd0);
    vecs[3]  = mk("rm_haz",    1, 5, 0, 0, 3'b100, 1, 5, 0, 0, 0, 4'h7, 1, 0, 2'd0);
    vecs[4]  = mk("rd_haz",    1, 0, 0, 6, 3'b001, 1, 6, 0, 0, 0, 4'h7, 1, 0, 2'd0);
    vecs[5]  = mk("all_miss",  1, 4, 1, 2, 3'b111, 1, 5, 0, 0, 0, 4'hF, 0, 0, 2'd0);
    vecs[6]  = mk("no_load",   1, 3, 3, 3, 3'b111, 0, 3, 0, 0, 0, 4'hF, 0, 0, 2'd0);
    vecs[7]  = mk("no_valid",  0, 3, 3, 3, 3'b111, 1, 3, 0, 0, 0, 4'hF, 0, 0, 2'd0);
    vecs[8]  = mk("mem_stall", 0, 0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 4'h0, 0, 0, 2'd2);
    vecs[9]  = mk("mem_done",  0, 0, 0, 0, 3'b000, 0, 0, 1, 1, 0, 4'hF, 0, 0, 2'd0);
    vecs[10] = mk("branch",    0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 4'hF, 1, 1, 2'd3);
    vecs[11] = mk("br_haz",    1, 0, 3, 0, 3'b010, 1, 3, 0, 0, 1, 4'hF, 1, 1, 2'd3);
    vecs[12] = mk("mem_br",    0, 0, 0, 0, 3'b000, 0, 0, 1, 0, 1, 4'h0, 0, 0, 2'd2);
    vecs[13] = mk("mem_haz",   1, 0, 3, 0, 3'b010, 1, 3, 1, 0, 0, 4'h0, 0, 0, 2'd2);

    // Reset held for two edges: everything frozen.
    rst = 1'b0;
    drive(idle_vec());
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk_out($sformatf("rst%0d", i), 4'h0, 0, 0);
    end
    check("rst_state", 32'(bus1.ctrl_state), 32'(RUN));
    rst = 1'b1;
    #1;
    chk_out("post_rst", 4'hF, 0, 0);
    check("post_rst_state", 32'(bus1.ctrl_state), 32'(RUN));
    check("post_rst_perf_stall", 32'(bus1.perf_stall_cnt), 32'd0);
    check("post_rst_perf_flush", 32'(bus1.perf_flush_cnt), 32'd0);

    // Table: each vector applied for one cycle from a fresh RUN state.
    for (int i = 0; i < 14; i++) begin
      do_reset();
      drive(vecs[i]);
      #1;
      chk_out(vecs[i].name, vecs[i].e_upd, vecs[i].e_bub, vecs[i].e_fl);
      cyc();
      check({vecs[i].name, "_next"}, 32'(bus1.ctrl_state), 32'(vecs[i].e_next));
      drive(idle_vec());
    end

    // Load-use stall length: 1 cycle for L=1, 2 cycles for L=2.
    do_reset();
    cur = vecs[1];
    drive(cur);
    #1;
    chk_out("ld0", 4'h7, 1, 0);
    check("ld0_l2_upd_if", 32'(bus2.update_if), 32'd0);
    cyc();
    check("ld0_state", 32'(bus1.ctrl_state), 32'(RUN));
    check("ld0_l2_state", 32'(bus2.ctrl_state), 32'(LOAD_STALL));
    cur.rl = 1'b0;   // bubble now sits in readreg
    drive(cur);
    #1;
    chk_out("ld1", 4'hF, 0, 0);
    check("ld1_l2_upd_if", 32'(bus2.update_if), 32'd0);
    check("ld1_l2_bub", 32'(bus2.bubble_rr), 32'd1);
    cyc();
    check("ld2_l2_state", 32'(bus2.ctrl_state), 32'(RUN));
    check("ld2_l2_upd_if", 32'(bus2.update_if), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    check("ld_perf_stall_l1", 32'(bus1.perf_stall_cnt), 32'd1);
    check("ld_perf_stall_l2", 32'(bus2.perf_stall_cnt), 32'd2);
`else
    check("ld_perf_stall_l1", 32'(bus1.perf_stall_cnt), 32'd0);
    check("ld_perf_stall_l2", 32'(bus2.perf_stall_cnt), 32'd0);
`endif
    drive(idle_vec());

    // Memory wait: 4 frozen cycles, release on the 5th.
    do_reset();
    cur = idle_vec();
    cur.mreq = 1'b1;
    drive(cur);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_out($sformatf("mw%0d", i), 4'h0, 0, 0);
      cyc();
    end
    check("mw_state", 32'(bus1.ctrl_state), 32'(MEM_WAIT));
    cur.mrdy = 1'b1;
    drive(cur);
    #1;
    chk_out("mw_done", 4'hF, 0, 0);
    cyc();
    check("mw_done_state", 32'(bus1.ctrl_state), 32'(RUN));
`ifdef HAZARD_PERF_CNT_EN
    check("mw_perf_stall", 32'(bus1.perf_stall_cnt), 32'd4);
`else
    check("mw_perf_stall", 32'(bus1.perf_stall_cnt), 32'd0);
`endif
    drive(idle_vec());

    // Branch together with hazard: flush wins, no LOAD_STALL.
    do_reset();
    cur = vecs[11];
    drive(cur);
    #1;
    chk_out("bh0", 4'hF, 1, 1);
    cyc();
    check("bh0_state", 32'(bus1.ctrl_state), 32'(FLUSH));
    check("bh0_l2_state", 32'(bus2.ctrl_state), 32'(FLUSH));
    drive(idle_vec());
    #1;
    chk_out("bh1", 4'hF, 1, 0);
    cyc();
    check("bh1_state", 32'(bus1.ctrl_state), 32'(RUN));
`ifdef HAZARD_PERF_CNT_EN
    check("bh_perf_flush", 32'(bus1.perf_flush_cnt), 32'd1);
`else
    check("bh_perf_flush", 32'(bus1.perf_flush_cnt), 32'd0);
`endif

    // Branch during MEM_WAIT is held and applied on release.
    do_reset();
    cur = idle_vec();
    cur.mreq = 1'b1;
    drive(cur);
    cyc();
    cur.br = 1'b1;
    drive(cur);
    #1;
    chk_out("pb0", 4'h0, 0, 0);
    cyc();
    cur.br = 1'b0;
    drive(cur);
    #1;
    chk_out("pb1", 4'h0, 0, 0);
    cyc();
    cur.mrdy = 1'b1;
    drive(cur);
    #1;
    chk_out("pb2", 4'hF, 1, 1);
    cyc();
    check("pb2_state", 32'(bus1.ctrl_state), 32'(FLUSH));
    drive(idle_vec());
    #1;
    chk_out("pb3", 4'hF, 1, 0);
    cyc();
    check("pb3_state", 32'(bus1.ctrl_state), 32'(RUN));

    // Reset mid-wait drops the pending branch.
    do_reset();
    cur = idle_vec();
    cur.mreq = 1'b1;
    drive(cur);
    cyc();
    cur.br = 1'b1;
    drive(cur);
    cyc();
    cur.br = 1'b0;
    drive(cur);
    rst = 1'b0;
    #1;
    chk_out("rp_rst", 4'h0, 0, 0);
    cyc();
    rst = 1'b1;
    #1;
    check("rp_state", 32'(bus1.ctrl_state), 32'(RUN));
    chk_out("rp_run", 4'h0, 0, 0);
    cyc();
    check("rp_wait", 32'(bus1.ctrl_state), 32'(MEM_WAIT));
    cur.mrdy = 1'b1;
    drive(cur);
    #1;
    chk_out("rp_done", 4'hF, 0, 0);
    cyc();
    check("rp_done_state", 32'(bus1.ctrl_state), 32'(RUN));
    drive(idle_vec());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
